// File: rtl/mult_ctrl_if.sv
// mult_ctrl_if: request/HI-LO bus between the CPU control unit, the Booth
// multiplier unit and mult_ctrl.
//   master : CPU control unit plus multiplier unit (drives requests, flush,
//            MTHI/MTLO, and product halves)
//   slave  : mult_ctrl (drives handshake ready, unit controls and operands,
//            HI/LO, busy, done)
interface mult_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wdata;
    logic             unit_clr;
    logic             unit_run;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic [WIDTH-1:0] unit_hi;
    logic [WIDTH-1:0] unit_lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output op_valid, op_a, op_b, flush, mthi_we, mtlo_we, wdata,
               unit_hi, unit_lo,
        input  op_ready, unit_clr, unit_run, unit_a, unit_b, hi, lo, busy, done
    );

    modport slave (
        input  op_valid, op_a, op_b, flush, mthi_we, mtlo_we, wdata,
               unit_hi, unit_lo,
        output op_ready, unit_clr, unit_run, unit_a, unit_b, hi, lo, busy, done
    );
endinterface

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencer and HI/LO owner for the iterative Booth multiplier.
// Accepts a request, clears the unit for one cycle, holds unit_run for
// MULT_LATENCY cycles, then captures the product into HI/LO with a one-cycle
// done pulse. Also services MTHI/MTLO writes and flush of an in-flight op.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mult_ctrl_if.slave (request handshake, flush, MTHI/MTLO,
//            unit control/operands/product, HI/LO, busy, done)
module mult_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MULT_LATENCY = 34
) (
    input  logic         clk,
    input  logic         reset,
    mult_ctrl_if.slave   bus
);
    localparam int unsigned CW = $clog2(MULT_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic [WIDTH-1:0] unit_b_q, unit_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             op_ready_w;

    // Handshake and unit clear are combinational so reset clears the unit at once
    assign op_ready_w   = (state_q == IDLE) & ~bus.flush;
    assign bus.op_ready = op_ready_w;
    assign bus.unit_clr = reset | (state_q == CLEAR);
    assign bus.busy     = (state_q != IDLE);
    assign bus.unit_run = run_q;
    assign bus.unit_a   = unit_a_q;
    assign bus.unit_b   = unit_b_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.done     = done_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        unit_a_d = unit_a_q;
        unit_b_d = unit_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        run_d    = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO and acceptance may coincide; capture later wins
                if (!bus.flush) begin
                    if (bus.mthi_we) hi_d = bus.wdata;
                    if (bus.mtlo_we) lo_d = bus.wdata;
                end
                if (bus.op_valid && op_ready_w) begin
                    unit_a_d = bus.op_a;
                    unit_b_d = bus.op_b;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = '0;
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    // Last RUN cycle: drop run so it is low during CAPTURE
                    if (cnt_q == CW'(MULT_LATENCY - 1)) begin
                        state_d = CAPTURE;
                    end else begin
                        run_d = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                if (bus.flush) begin
                    cnt_d = '0;
                end else begin
                    hi_d   = bus.unit_hi;
                    lo_d   = bus.unit_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            unit_a_q <= '0;
            unit_b_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            unit_a_q <= unit_a_d;
            unit_b_q <= unit_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end
endmodule
